key_store_reader: RTL

KEY_STORE_READER -- requirements
Module: key_store_reader

---
 rtl/key_store_reader_if.sv | 19 +
 rtl/key_store_reader.sv | 97 +++++++++
 2 files changed

// File: rtl/key_store_reader_if.sv
// key_store_reader_if: read request/response channel of the key store.
interface key_store_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_priv;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    modport master (
        output req_valid, req_addr, req_priv, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, req_priv, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/key_store_reader.sv
// key_store_reader: word store with a privileged, lockable key entry and violation counter.
module key_store_reader #(
    parameter logic [31:0] KEY     = 32'h1035_9987,
    parameter int          KEY_IDX = 0,
    parameter int          DEPTH   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    key_store_reader_if.slave   bus,
    input  logic                we,
    input  logic [31:0]         waddr,
    input  logic [31:0]         wd,
    input  logic                lock_set,
    output logic [7:0]          viol_cnt
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] KI = IW'(KEY_IDX);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t      state, state_nx;
    logic        up, lock, priv_q, err_q;
    logic [31:0] addr_q, data_q;
    logic [31:0] mem [DEPTH];
    logic [IW-1:0] ridx, widx;
    logic        rd_bad, deny, fail, w_good, w_ok, w_key, deny_ev;
    logic [8:0]  sum;

    assign ridx    = addr_q[IW+1:2];
    assign widx    = waddr[IW+1:2];
    assign rd_bad  = addr_q[1:0] != 2'b00 || addr_q[31:7] != '0;
    // a lock_set arriving during the lookup already denies that lookup
    assign deny    = !rd_bad && ridx == KI && (!priv_q || lock || lock_set);
    assign fail    = rd_bad || deny;
    assign w_good  = we && waddr[1:0] == 2'b00 && waddr[31:7] == '0;
    assign w_ok    = w_good && widx != KI;
    assign w_key   = w_good && widx == KI;
    assign deny_ev = state == LOOKUP && deny;
    assign sum     = {1'b0, viol_cnt} + {8'd0, deny_ev} + {8'd0, w_key};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (bus.req_valid && bus.req_ready) ? LOOKUP : IDLE;
            LOOKUP:  state_nx = RESP;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = up && state == IDLE;
        bus.rsp_valid = state == RESP;
        bus.rsp_data  = data_q;
        bus.rsp_err   = err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up       <= 1'b0;
            lock     <= 1'b0;
            priv_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            viol_cnt <= '0;
        end else begin
            up       <= 1'b1;
            lock     <= lock || lock_set;
            viol_cnt <= sum[8] ? 8'hFF : sum[7:0];
            if (bus.req_valid && bus.req_ready) begin
                addr_q <= bus.req_addr;
                priv_q <= bus.req_priv;
            end
            if (state == LOOKUP) begin
                err_q  <= fail;
                data_q <= fail ? '0 : mem[ridx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= (i == KEY_IDX) ? KEY : '0;
        end else if (w_ok) begin
            mem[widx] <= wd;
        end
    end
endmodule
